// File: rtl/serie_paralelo_rx_pkg.sv
// phy_rx_pkg: shared PHY RX constants (comma byte, lock count default, FSM state encoding)
package phy_rx_pkg;
  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
  localparam int LOCK_COUNT_DEFAULT = 4;
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;
endpackage

// File: rtl/serie_paralelo_rx_if.sv
// serie_paralelo_rx_if: serial-in / parallel-out bus of one RX lane
// data_in: serial bit (MSB first); data_out/valid_out: received byte; byte_strobe: byte done; active: locked
interface serie_paralelo_rx_if;
  logic data_in;
  logic [7:0] data_out;
  logic valid_out;
  logic byte_strobe;
  logic active;
  modport master (output data_in, input data_out, valid_out, byte_strobe, active);
  modport slave (input data_in, output data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/serie_paralelo_rx_shift8.sv
// rx_shift8: serial shift register with candidate byte and mod-8 bit counter
// ports: clk_8f, reset (async, low), data_in, clr (sync bit counter clear), cand, last_bit
module rx_shift8 (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       clr,
  output logic [7:0] cand,
  output logic       last_bit
);
  // only the last seven bits are needed; the incoming bit completes the byte
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  assign cand = {sr, data_in};
  assign last_bit = bit_cnt == 3'd7;
  always_ff @(posedge clk_8f or negedge reset)
    if (!reset) begin
      sr <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= cand[6:0];
      bit_cnt <= clr ? 3'd0 : bit_cnt + 3'd1;
    end
endmodule

// File: rtl/serie_paralelo_rx.sv
// serie_paralelo_rx: comma-aligned serial-to-parallel receiver for one lane
// ports: clk_8f (bit clock), reset (async, low), bus (slave: data_in in; data_out, valid_out, byte_strobe, active out)
module serie_paralelo_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEFAULT,
  parameter int LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input logic clk_8f,
  input logic reset,
  serie_paralelo_rx_if.slave bus
);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  rx_state_t state;
  logic [3:0] comma_cnt;
  logic [7:0] cand;
  logic last_bit;
  logic is_comma;
  logic [3:0] cnt_next;
  assign is_comma = cand == COMMA;
  assign cnt_next = comma_cnt + 4'd1;
  // holding the counter clear while hunting makes the comma-match edge the byte boundary
  rx_shift8 u_shift (
    .clk_8f(clk_8f),
    .reset(reset),
    .data_in(bus.data_in),
    .clr(state == SEARCH),
    .cand(cand),
    .last_bit(last_bit)
  );
  always_ff @(posedge clk_8f or negedge reset)
    if (!reset) begin
      state <= SEARCH;
      comma_cnt <= '0;
      bus.data_out <= '0;
      bus.valid_out <= 1'b0;
      bus.byte_strobe <= 1'b0;
      bus.active <= 1'b0;
    end else begin
      bus.byte_strobe <= state == LOCKED && last_bit;
      case (state)
        SEARCH:
          if (is_comma) begin
            comma_cnt <= 4'd1;
            state <= LC == 4'd1 ? LOCKED : COUNT;
            bus.active <= LC == 4'd1;
          end
        COUNT:
          if (last_bit) begin
            // a broken run goes back to hunting without re-testing this byte
            if (!is_comma) begin
              state <= SEARCH;
              comma_cnt <= '0;
            end else begin
              comma_cnt <= cnt_next;
              if (cnt_next == LC) begin
                state <= LOCKED;
                bus.active <= 1'b1;
              end
            end
          end
        LOCKED:
          if (last_bit) begin
            bus.valid_out <= !is_comma;
            if (!is_comma) bus.data_out <= cand;
          end
        default: state <= SEARCH;
      endcase
    end
endmodule

// File: doc/serie_paralelo_rx.md
# serie_paralelo_rx

Single-lane serial-to-parallel receiver: the receive-side counterpart of the PHY TX parallel-to-serial stage. It takes the MSB-first serial bitstream on `clk_8f` and finds byte alignment by hunting for the idle/comma byte at any bit offset. It declares the link active after `LOCK_COUNT` consecutive aligned commas, then emits one byte per 8 bits with a valid flag. Two instances, one per lane, feed the RX byte un-striping stage.

## Interface
Parameters:
- `COMMA`, default 8'hBC: idle/alignment byte the transmitter sends when it has no valid data.
- `LOCK_COUNT`, default 4: number of consecutive aligned commas required to enter LOCKED; legal range 1..15.

Ports:
- `clk_8f`  input  1  bit clock; all state is updated on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `data_in`  input  1  serial bit, MSB of each byte first.
- `data_out`  output  8  last received data byte.
- `valid_out`  output  1  high for the byte period following reception of a non-comma byte while LOCKED.
- `byte_strobe`  output  1  one-cycle pulse on the edge a byte completes while LOCKED.
- `active`  output  1  high while in LOCKED.

## Operation
- The 8-bit shift register updates every cycle: `sr <= {sr[6:0], data_in}`. The candidate byte is `cand = {sr[6:0], data_in}`.
- SEARCH (reset state):
  - `cand` is compared with `COMMA` every cycle.
  - On a match, go to COUNT with `comma_cnt = 1` and `bit_cnt = 0`. This edge defines the byte boundary.
  - If `LOCK_COUNT == 1`, go directly to LOCKED instead.
- COUNT:
  - `bit_cnt` increments mod 8.
  - At `bit_cnt == 7`, `cand` is a complete aligned byte:
    - If `cand == COMMA`, `comma_cnt` increments. When it reaches `LOCK_COUNT`, go to LOCKED and set `active = 1`.
    - If `cand != COMMA`, return to SEARCH and clear `comma_cnt`. The same `cand` is not re-checked for a comma at this edge.
- LOCKED:
  - `bit_cnt` keeps running mod 8.
  - At `bit_cnt == 7`, `byte_strobe` pulses for one cycle.
  - If `cand != COMMA`: `data_out <= cand` and `valid_out <= 1`.
  - If `cand == COMMA`: `valid_out <= 0` and `data_out` holds its previous value.
  - `valid_out` and `data_out` hold until the next byte boundary.
- LOCKED persists until reset. There is no loss-of-lock detection in this block.
- `data_out`, `valid_out` and `byte_strobe` never change outside LOCKED.

## Timing
- Reset values (applied immediately on `reset` falling, asynchronously):
  - `data_out = 0`, `valid_out = 0`, `byte_strobe = 0`, `active = 0`.
  - State = SEARCH, `sr = 0`, `bit_cnt = 0`, `comma_cnt = 0`.
- Reset mid-operation discards any partial byte. Release of reset is sampled synchronously: the first shift happens on the first rising edge with `reset` high.
- Latency: all outputs are registered and update on the same edge that samples the last bit (LSB) of the byte. They are visible in the following cycle.
- Lock time with aligned input: `active` rises on the edge sampling the LSB of comma number `LOCK_COUNT`, i.e. after `8*LOCK_COUNT` bits.
- With an offset of k junk bits, add k cycles, provided the junk plus the comma stream creates no false comma match.
- Steady state: `byte_strobe` period is exactly 8 cycles; `valid_out` changes only at strobe edges.

## Structure
- Shared package `phy_rx_pkg` holds:
  - the `COMMA` default (8'hBC), also imported by the TX side;
  - the state encoding SEARCH = 2'd0, COUNT = 2'd1, LOCKED = 2'd2;
  - the `LOCK_COUNT` default.
- One sub-module, `rx_shift8`: the shift register, `cand` output and mod-8 `bit_cnt` with a synchronous count-clear input and a `last_bit` flag.
- FSM, comma counter and output registers sit in `serie_paralelo_rx`.

## Test plan
- Reset mid-stream: assert `reset` low between clock edges while LOCKED with `data_out = 0x55` -> all outputs are 0 before the next edge; the state returns to SEARCH.
- Aligned lock: 4×0xBC then 0x55 -> `active` rises at bit 32; at bit 40 `byte_strobe = 1`, `valid_out = 1`, `data_out = 0x55`.
- Bit-offset lock: 3 bits `101`, then 4×0xBC, then 0x3C -> `active` rises at bit 35; `data_out = 0x3C` with `valid_out = 1` at bit 43.
- Broken run: 0xBC, 0xBC, 0x12, then 4×0xBC -> `active` stays 0 through bit 24; the bench then checks `active` against the cycle in which the reference model regains lock.
- Commas in data: LOCKED, then 0xA5, 0xBC, 0x3C -> `valid_out` is 1, 0, 1 across the three byte periods; `data_out` is 0xA5, 0xA5, 0x3C; `byte_strobe` fires every 8 cycles.
- `LOCK_COUNT = 1` variant: a single 0xBC then 0x77 -> `active` rises at bit 8; `data_out = 0x77` with `valid_out = 1` at bit 16.
